data_ram_bist: RTL

//  Memory built-in self-test initiator. Drives the data-RAM port (ce/we/addr/sel/data) in

---
 rtl/data_ram_bist.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/data_ram_bist.sv
// March-style built-in self-test for data_ram: owns the RAM port while busy,
// runs W(P) / RW(P,~P) / RW(~P,P) / RW(P,~P lanes 2,0) / R(MX), and reports the first bad word.
module data_ram_bist #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] PATTERN     = 32'hA5A5_5A5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic [31:0] fail_expect,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  localparam int             IW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IW-1:0]  LAST   = IW'(DEPTH_WORDS - 1);
  localparam logic [31:0]    PAT_N  = ~PATTERN;
  localparam logic [31:0]    PAT_MX = {PATTERN[31:24], PAT_N[23:16], PATTERN[15:8], PAT_N[7:0]};

  typedef enum logic [3:0] {
    S_IDLE, S_M0_W, S_M1_R, S_M1_W, S_M2_R, S_M2_W, S_M3_R, S_M3_W, S_M4_R, S_END
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic          accept;
  logic          is_read;
  logic [31:0]   expect_v;
  logic          mismatch;
  logic          fail_seen;

  logic          ce_nx, we_nx;
  logic [3:0]    sel_nx;
  logic [31:0]   data_nx, addr_nx;

  // Value the current read cycle must return; compared against the asynchronous read data.
  always_comb begin
    is_read  = 1'b0;
    expect_v = '0;
    unique case (state)
      S_M1_R:  begin is_read = 1'b1; expect_v = PATTERN; end
      S_M2_R:  begin is_read = 1'b1; expect_v = PAT_N;   end
      S_M3_R:  begin is_read = 1'b1; expect_v = PATTERN; end
      S_M4_R:  begin is_read = 1'b1; expect_v = PAT_MX;  end
      default: ;
    endcase
    mismatch = is_read && (ram_data_i != expect_v);
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    accept   = 1'b0;
    unique case (state)
      S_IDLE: begin
        idx_nx = '0;
        if (start) begin
          accept   = 1'b1;
          state_nx = S_M0_W;
        end
      end
      S_M0_W: begin
        if (idx == LAST) begin state_nx = S_M1_R; idx_nx = '0; end
        else idx_nx = idx + IW'(1);
      end
      S_M1_R: state_nx = mismatch ? S_END : S_M1_W;
      S_M1_W: begin
        if (idx == LAST) begin state_nx = S_M2_R; idx_nx = LAST; end
        else begin state_nx = S_M1_R; idx_nx = idx + IW'(1); end
      end
      S_M2_R: state_nx = mismatch ? S_END : S_M2_W;
      S_M2_W: begin
        if (idx == '0) begin state_nx = S_M3_R; idx_nx = '0; end
        else begin state_nx = S_M2_R; idx_nx = idx - IW'(1); end
      end
      S_M3_R: state_nx = mismatch ? S_END : S_M3_W;
      S_M3_W: begin
        if (idx == LAST) begin state_nx = S_M4_R; idx_nx = LAST; end
        else begin state_nx = S_M3_R; idx_nx = idx + IW'(1); end
      end
      S_M4_R: begin
        if (mismatch || idx == '0) state_nx = S_END;
        else idx_nx = idx - IW'(1);
      end
      S_END: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  // RAM port for the upcoming cycle, decoded from the next state so the port is registered.
  always_comb begin
    ce_nx   = 1'b0;
    we_nx   = 1'b0;
    sel_nx  = 4'b0000;
    data_nx = '0;
    unique case (state_nx)
      S_M0_W:  begin ce_nx = 1'b1; we_nx = 1'b1; sel_nx = 4'b1111; data_nx = PATTERN; end
      S_M1_W:  begin ce_nx = 1'b1; we_nx = 1'b1; sel_nx = 4'b1111; data_nx = PAT_N;   end
      S_M2_W:  begin ce_nx = 1'b1; we_nx = 1'b1; sel_nx = 4'b1111; data_nx = PATTERN; end
      S_M3_W:  begin ce_nx = 1'b1; we_nx = 1'b1; sel_nx = 4'b0101; data_nx = PAT_N;   end
      S_M1_R, S_M2_R, S_M3_R, S_M4_R: ce_nx = 1'b1;
      default: ;
    endcase
    addr_nx = ce_nx ? (ADDR_BASE + 32'({idx_nx, 2'b00})) : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_seen   <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
      fail_expect <= '0;
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_sel_o   <= 4'b0000;
      ram_data_o  <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      busy       <= (state_nx != S_IDLE) && (state_nx != S_END);
      ram_ce_o   <= ce_nx;
      ram_we_o   <= we_nx;
      ram_addr_o <= addr_nx;
      ram_sel_o  <= sel_nx;
      ram_data_o <= data_nx;
      if (accept) begin
        done        <= 1'b0;
        pass        <= 1'b0;
        fail_seen   <= 1'b0;
        fail_addr   <= '0;
        fail_data   <= '0;
        fail_expect <= '0;
      end
      if (mismatch) begin
        fail_seen   <= 1'b1;
        fail_addr   <= ram_addr_o;
        fail_data   <= ram_data_i;
        fail_expect <= expect_v;
      end
      if (state == S_END) begin
        done <= 1'b1;
        pass <= ~fail_seen;
      end
    end
  end

endmodule
